// File: rtl/gsim_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gsim_pkg
// Purpose  : Shared types and widths for the GSIM matrix-memory server.
// Revision : 1.0 - initial release
// ============================================================================
package gsim_pkg;

  localparam int ROW_W       = 256;
  localparam int BEAT_W      = 64;
  localparam int BEAT_NUM    = 4;
  localparam int ADDR_W      = 10;
  localparam int SRAM_ADDR_W = 12;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } gsim_state_e;

endpackage
`default_nettype wire

// File: rtl/gsim_stall_lfsr.sv
`default_nettype none
// ============================================================================
// Module   : gsim_stall_lfsr
// Purpose  : 16-bit Fibonacci LFSR (taps 16,14,13,11) with stall decode.
// Revision : 1.0 - initial release
// ============================================================================
module gsim_stall_lfsr
  import gsim_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  output logic       o_stall,
  output logic [1:0] o_extra
);

  logic [15:0] r_lfsr;
  logic        w_fb;

  assign w_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= {r_lfsr[14:0], w_fb};
    end
  end

  assign o_stall = (r_lfsr[1:0] == 2'b00);
  assign o_extra = r_lfsr[3:2];

endmodule
`default_nettype wire

// File: rtl/gsim_mat_mem_server.sv
`default_nettype none
// ============================================================================
// Module   : gsim_mat_mem_server
// Purpose  : Serves 256-bit rows as four 64-bit beats from a 1-cycle SRAM.
//            Define GSIM_MEM_STALL_EN to add pseudo-random handshake stalls.
// Revision : 1.0 - initial release
// ============================================================================
module gsim_mat_mem_server
  import gsim_pkg::*;
#(
  parameter int EXTRA_LAT = 0,
  parameter int MAX_WORDS = 1024
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_mem_rreq,
  input  logic [ADDR_W-1:0]      i_mem_addr,
  output logic                   o_mem_rrdy,
  output logic [ROW_W-1:0]       o_mem_dout,
  output logic                   o_mem_dout_vld,
  output logic                   o_sram_ren,
  output logic [SRAM_ADDR_W-1:0] o_sram_addr,
  input  logic [BEAT_W-1:0]      i_sram_rdata,
  output logic                   o_err
);

  gsim_state_e            r_state;
  logic [ADDR_W-1:0]      r_row;
  logic [2:0]             r_cnt;
  logic [4:0]             r_wait;
  logic                   r_err_pend;
  logic [ROW_W-1:0]       r_buf;
  logic [ROW_W-1:0]       r_dout;
  logic                   r_rrdy;
  logic                   r_vld;
  logic                   r_err;
  logic                   r_ren;
  logic [SRAM_ADDR_W-1:0] r_saddr;

  logic                   w_stall;
  logic [1:0]             w_stall_extra;
  logic                   w_accept;
  logic                   w_oor;
  logic [4:0]             w_extra;
  logic [1:0]             w_cap_idx;
  logic [1:0]             w_next_beat;
  logic [ROW_W-1:0]       w_row_full;

`ifdef GSIM_MEM_STALL_EN
  gsim_stall_lfsr u_stall (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .o_stall (w_stall),
    .o_extra (w_stall_extra)
  );
`else
  assign w_stall       = 1'b0;
  assign w_stall_extra = 2'b00;
`endif

  // Stall masking only applies while idle; RESP must always offer ready.
  assign o_mem_rrdy  = r_rrdy & ~(w_stall & (r_state == IDLE));
  assign w_accept    = i_mem_rreq & o_mem_rrdy;
  assign w_oor       = ({1'b0, i_mem_addr} >= 11'(MAX_WORDS));
  assign w_extra     = 5'(EXTRA_LAT) + {3'b000, w_stall_extra};
  assign w_cap_idx   = 2'(r_cnt - 3'd1);
  assign w_next_beat = 2'(r_cnt + 3'd1);
  assign w_row_full  = {i_sram_rdata, r_buf[3*BEAT_W-1:0]};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_row      <= '0;
      r_cnt      <= '0;
      r_wait     <= '0;
      r_err_pend <= 1'b0;
      r_buf      <= '0;
      r_dout     <= '0;
      r_rrdy     <= 1'b0;
      r_vld      <= 1'b0;
      r_err      <= 1'b0;
      r_ren      <= 1'b0;
      r_saddr    <= '0;
    end else begin
      r_vld <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        IDLE, RESP: begin
          r_rrdy  <= 1'b1;
          r_state <= IDLE;
          if (w_accept) begin
            r_rrdy <= 1'b0;
            r_row  <= i_mem_addr;
            r_cnt  <= 3'd0;
            if (w_oor) begin
              // No SRAM traffic; the wait covers the skipped fetch window.
              r_state    <= WAIT;
              r_err_pend <= 1'b1;
              r_wait     <= 5'd4 + w_extra;
            end else begin
              r_state    <= FETCH;
              r_err_pend <= 1'b0;
              r_ren      <= 1'b1;
              r_saddr    <= {i_mem_addr, 2'd0};
            end
          end
        end
        FETCH: begin
          // Issue runs one beat ahead of capture because of SRAM latency.
          r_cnt <= r_cnt + 3'd1;
          r_ren <= (r_cnt < 3'd3);
          if (r_cnt < 3'd3) begin
            r_saddr <= {r_row, w_next_beat};
          end
          if (r_cnt != 3'd0) begin
            r_buf[{w_cap_idx, 6'd0} +: BEAT_W] <= i_sram_rdata;
          end
          if (r_cnt == 3'd4) begin
            if (w_extra == 5'd0) begin
              r_state <= RESP;
              r_vld   <= 1'b1;
              r_rrdy  <= 1'b1;
              r_dout  <= w_row_full;
            end else begin
              r_state <= WAIT;
              r_wait  <= w_extra - 5'd1;
            end
          end
        end
        WAIT: begin
          if (r_wait == 5'd0) begin
            r_state <= RESP;
            r_vld   <= 1'b1;
            r_err   <= r_err_pend;
            r_rrdy  <= 1'b1;
            r_dout  <= r_err_pend ? '0 : r_buf;
          end else begin
            r_wait <= r_wait - 5'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_mem_dout     = r_dout;
  assign o_mem_dout_vld = r_vld;
  assign o_err          = r_err;
  assign o_sram_ren     = r_ren;
  assign o_sram_addr    = r_saddr;

endmodule
`default_nettype wire

// File: tb/tb_gsim_mat_mem_server.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_gsim_mat_mem_server
// Purpose  : Scoreboard bench for two server instances (EXTRA_LAT 0 / 3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_gsim_mat_mem_server;

  localparam int NI = 2;
`ifdef GSIM_MEM_STALL_EN
  localparam int c_b2b   = 200;
  localparam int c_slack = 3;
`else
  localparam int c_b2b   = 18;
  localparam int c_slack = 0;
`endif

  typedef struct {
    logic [255:0] data;
    logic         err;
    int           t_acc;
    logic [9:0]   row;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n [NI];
  logic         rreq  [NI];
  logic [9:0]   addr  [NI];
  logic         rrdy  [NI];
  logic [255:0] dout  [NI];
  logic         vld   [NI];
  logic         ren   [NI];
  logic [11:0]  saddr [NI];
  logic         err   [NI];

  exp_t sb_q [NI][$];
  int   beat_idx [NI];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int el(input int i);
    return (i == 0) ? 0 : 3;
  endfunction

  function automatic int mw(input int i);
    return (i == 0) ? 512 : 1024;
  endfunction

  // Backing-store content as a function of beat address.
  function automatic logic [63:0] beat_pat(input logic [11:0] a);
    return {4'hA, a, 4'h5, ~a, 16'(a) ^ 16'h1234, 4'hC, a};
  endfunction

  function automatic logic [255:0] ref_row(input int i, input logic [9:0] row);
    logic [255:0] r;
    r = '0;
    if (int'(row) < mw(i)) begin
      for (int k = 0; k < 4; k++) r[64*k +: 64] = beat_pat({row, 2'(k)});
    end
    return r;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_inst
    logic [63:0] sram_rdata;
    always @(posedge clk) if (ren[g]) sram_rdata <= beat_pat(saddr[g]);

    gsim_mat_mem_server #(
      .EXTRA_LAT ((g == 0) ? 0 : 3),
      .MAX_WORDS ((g == 0) ? 512 : 1024)
    ) u_dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n[g]),
      .i_mem_rreq     (rreq[g]),
      .i_mem_addr     (addr[g]),
      .o_mem_rrdy     (rrdy[g]),
      .o_mem_dout     (dout[g]),
      .o_mem_dout_vld (vld[g]),
      .o_sram_ren     (ren[g]),
      .o_sram_addr    (saddr[g]),
      .i_sram_rdata   (sram_rdata),
      .o_err          (err[g])
    );
  end

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s t=%0t act=%h exp=%h", nm, $time, act, expv);
    end
  endtask

  // Monitor: pops the scoreboard on every valid pulse, polices idle/busy outputs.
  always @(negedge clk) begin
    exp_t e;
    int   lat;
    for (int i = 0; i < NI; i++) begin
      if (!rst_n[i]) begin
        beat_idx[i] = 0;
        chk("reset_ctl", {vld[i], err[i], ren[i], rrdy[i]}, 4'b0000);
        chk("reset_dout", dout[i], '0);
      end else if (sb_q[i].size() == 0) begin
        chk("idle_ren", ren[i], 1'b0);
        chk("idle_vld", vld[i], 1'b0);
        chk("idle_err", err[i], 1'b0);
      end else begin
        e = sb_q[i][0];
        if (ren[i]) begin
          chk("sram_addr", saddr[i], {e.row, 2'(beat_idx[i])});
          beat_idx[i]++;
        end
        if (vld[i]) begin
          void'(sb_q[i].pop_front());
          lat = cyc - e.t_acc + 1;
          chk("dout", dout[i], e.data);
          chk("err_flag", err[i], e.err);
          chk("beat_count", beat_idx[i], e.err ? 0 : 4);
          chk("rrdy_resp", rrdy[i], 1'b1);
          total++;
          if (lat < 6 + el(i) || lat > 6 + el(i) + c_slack) begin
            bad++;
            $display("FAIL latency inst=%0d row=%0d act=%0d exp=%0d..%0d",
                     i, e.row, lat, 6 + el(i), 6 + el(i) + c_slack);
          end
          beat_idx[i] = 0;
        end else if (cyc >= e.t_acc) begin
          chk("rrdy_busy", rrdy[i], 1'b0);
          chk("err_early", err[i], 1'b0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int i);
    rst_n[i] = 1'b0;
    rreq[i]  = 1'b0;
    addr[i]  = '0;
    sb_q[i].delete();
    repeat (3) tick();
    rst_n[i] = 1'b1;
    chk("rrdy_in_reset", rrdy[i], 1'b0);
    tick();
    chk("rrdy_after_release", rrdy[i], 1'b1);
  endtask

  task automatic issue(input int i, input logic [9:0] row);
    int n;
    n = 0;
    addr[i] = row;
    rreq[i] = 1'b1;
    while (!rrdy[i] && n < 64) begin
      tick();
      n++;
    end
    if (!rrdy[i]) begin
      total++;
      bad++;
      $display("FAIL accept_timeout inst=%0d row=%0d", i, row);
      rreq[i] = 1'b0;
      return;
    end
    sb_q[i].push_back('{data: ref_row(i, row), err: (int'(row) >= mw(i)),
                        t_acc: cyc + 1, row: row});
    tick();
  endtask

  task automatic wait_done(input int i);
    int n;
    n = 0;
    while (sb_q[i].size() != 0 && n < 300) begin
      tick();
      n++;
    end
    if (sb_q[i].size() != 0) begin
      total++;
      bad++;
      $display("FAIL response_timeout inst=%0d pending=%0d", i, sb_q[i].size());
      sb_q[i].delete();
    end
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      rst_n[i] = 1'b0;
      rreq[i]  = 1'b0;
      addr[i]  = '0;
    end
    for (int i = 0; i < NI; i++) begin
      do_reset(i);
      repeat (2) tick();

      // Single request, request line dropped right after accept.
      issue(i, 10'd5);
      rreq[i] = 1'b0;
      wait_done(i);

      // Request held high, address moved on as soon as each row is taken.
      for (int r = 0; r < c_b2b; r++) issue(i, 10'(r));
      rreq[i] = 1'b0;
      wait_done(i);

      // Row 600 is out of range only for the 512-row instance.
      issue(i, 10'd600);
      rreq[i] = 1'b0;
      wait_done(i);
      issue(i, 10'd1);
      rreq[i] = 1'b0;
      wait_done(i);

      // Reset in the middle of a fetch: nothing may come back.
      issue(i, 10'd9);
      rreq[i] = 1'b0;
      tick();
      tick();
      #2;
      rst_n[i] = 1'b0;
      #1;
      chk("async_ren_drop", ren[i], 1'b0);
      chk("async_rrdy_drop", rrdy[i], 1'b0);
      sb_q[i].delete();
      repeat (2) tick();
      rst_n[i] = 1'b1;
      repeat (12) tick();
      issue(i, 10'd33);
      rreq[i] = 1'b0;
      wait_done(i);

      // Random rows, random gaps and random back-to-back bursts.
      for (int r = 0; r < 40; r++) begin
        issue(i, 10'($urandom_range(0, 1023)));
        if ($urandom_range(0, 1) == 0) begin
          rreq[i] = 1'b0;
          repeat ($urandom_range(0, 8)) tick();
        end
      end
      rreq[i] = 1'b0;
      wait_done(i);
      repeat (4) tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
